// File: rtl/demux1_4_stream_if.sv
// Stream bundle for the 1-to-4 demultiplexer.
// Input beat side plus four registered output ports.
interface demux1_4_stream_if #(
  parameter int N = 4
);
  logic [N-1:0] in_data;
  logic [1:0]   in_dest;
  logic         in_last;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] out0_data;
  logic [N-1:0] out1_data;
  logic [N-1:0] out2_data;
  logic [N-1:0] out3_data;
  logic [3:0]   out_valid;
  logic [3:0]   out_last;
  logic [3:0]   out_ready;

  modport master (
    output in_data, in_dest, in_last, in_valid,
    input  in_ready,
    input  out0_data, out1_data, out2_data, out3_data,
    input  out_valid, out_last,
    output out_ready
  );

  modport slave (
    input  in_data, in_dest, in_last, in_valid,
    output in_ready,
    output out0_data, out1_data, out2_data, out3_data,
    output out_valid, out_last,
    input  out_ready
  );
endinterface

// File: rtl/demux1_4_stream.sv
// Registered 1-to-4 stream demux, destination locked per packet.
// Each output owns a one-entry register so ports stall independently.
module demux1_4_stream #(
  parameter int N = 4
) (
  input logic               clk,
  input logic               rst_n,
  demux1_4_stream_if.slave  bus
);
  typedef enum logic {
    IDLE,
    LOCKED
  } state_t;

  state_t       state_q;
  state_t       state_d;
  logic [1:0]   dest_q;
  logic [1:0]   dest_d;
  logic [1:0]   d;
  logic         acc;
  logic [N-1:0] data_q [4];
  logic [3:0]   last_q;
  logic [3:0]   valid_q;

  assign d = (state_q == IDLE) ? bus.in_dest : dest_q;
  assign bus.in_ready =
    rst_n & (~valid_q[d] | bus.out_ready[d]);
  assign acc = bus.in_valid & bus.in_ready;

  assign bus.out0_data = data_q[0];
  assign bus.out1_data = data_q[1];
  assign bus.out2_data = data_q[2];
  assign bus.out3_data = data_q[3];
  assign bus.out_valid = valid_q;
  assign bus.out_last  = last_q;

  always_comb begin
    state_d = state_q;
    dest_d  = dest_q;
    unique case (state_q)
      IDLE: begin
        if (acc && !bus.in_last) begin
          dest_d  = bus.in_dest;
          state_d = LOCKED;
        end
      end
      LOCKED: begin
        if (acc && bus.in_last) state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      dest_q  <= '0;
      valid_q <= '0;
      last_q  <= '0;
      for (int k = 0; k < 4; k++) data_q[k] <= '0;
    end else begin
      state_q <= state_d;
      dest_q  <= dest_d;
      // a load wins over a drain so the slot refills at full rate
      for (int k = 0; k < 4; k++) begin
        if (acc && d == 2'(k)) begin
          data_q[k]  <= bus.in_data;
          last_q[k]  <= bus.in_last;
          valid_q[k] <= 1'b1;
        end else if (bus.out_ready[k]) begin
          valid_q[k] <= 1'b0;
        end
      end
    end
  end
endmodule
